// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between CPU writeback and a
// buffered I/O requester, with a starvation counter that forces FIFO drains.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  input  logic        io_valid,
  output logic        io_ready,
  input  logic [4:0]  io_waddr,
  input  logic [31:0] io_wdata,
  output logic        stall_cpu,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [2:0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CPU,
    GRANT_FIFO
  } grant_e;

  grant_e        grant;
  logic          cpu_req;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    addr_mem_q [DEPTH];
  logic [4:0]    addr_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  assign fifo_nonempty = (count_q != '0);
  assign io_ready      = (count_q < CW'(DEPTH));
  assign stall_cpu     = (starve_q == SW'(STARVE_LIMIT)) && fifo_nonempty;
  assign cpu_req       = cpu_we && (cpu_waddr != 5'd0);
  // Writes to r0 complete the handshake but are dropped before the FIFO.
  assign push          = io_valid && io_ready && (io_waddr != 5'd0);
  assign pop           = (grant == GRANT_FIFO);

  always_comb begin
    grant    = GRANT_NONE;
    starve_d = '0;
    if (stall_cpu) begin
      grant = GRANT_FIFO;
    end else if (cpu_req) begin
      grant = GRANT_CPU;
      if (fifo_nonempty) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (fifo_nonempty) begin
      grant = GRANT_FIFO;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[tail_q] = io_waddr;
      data_mem_d[tail_q] = io_wdata;
      tail_d             = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Address and data hold their last value when nothing is granted.
  always_comb begin
    we_d    = (grant != GRANT_NONE);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (grant)
      GRANT_CPU: begin
        waddr_d = cpu_waddr;
        wdata_d = cpu_wdata;
      end
      GRANT_FIFO: begin
        waddr_d = addr_mem_q[head_q];
        wdata_d = data_mem_q[head_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage needs no reset: the cleared count marks every entry invalid.
  always_ff @(posedge clock) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = waddr_q;
  assign data_writeReg    = wdata_q;
  assign fifo_count       = 3'(count_q);

endmodule
